// File: rtl/ysyx_2022040010_imem_pkg.sv
// Shared definitions for the instruction-memory responder: bus widths, the
// default NOP word, and the LOAD/RUN state encoding.
package ysyx_2022040010_imem_pkg;

    localparam int InstBus     = 32;
    localparam int InstAddrBus = 64;

    // addi x0, x0, 0
    localparam logic [InstBus-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_t;

endpackage

// File: rtl/ysyx_2022040010_imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port and one
// registered read port. Contents and read register are intentionally not reset.
module ysyx_2022040010_imem_array
    import ysyx_2022040010_imem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [InstBus-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [InstBus-1:0] rdata
);

    logic [InstBus-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ysyx_2022040010_imem_resp.sv
// Instruction-memory responder: filled through a valid/ready load port, then
// serves registered fetches and counts them. Optional address checking is
// enabled by defining YSYX_2022040010_IMEM_CHECK_EN.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_LOAD | accepting load words into the array, fetches ignored
//   ST_RUN  | serving fetches; left only by reset
module ysyx_2022040010_imem_resp
    import ysyx_2022040010_imem_pkg::*;
#(
    parameter int unsigned             DEPTH     = 1024,
    parameter logic [InstAddrBus-1:0]  BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter logic [InstBus-1:0]      NOP_INST  = DEFAULT_NOP_INST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_ce_i,
    input  logic [InstAddrBus-1:0] inst_addr_i,
    output logic [InstBus-1:0]     inst_data_o,
    output logic                   inst_valid_o,
    output logic                   inst_err_o,
    input  logic                   load_valid_i,
    output logic                   load_ready_o,
    input  logic [InstBus-1:0]     load_data_i,
    input  logic                   load_last_i,
    output logic                   run_o,
    output logic [31:0]            fetch_cnt_o
);

    localparam int AW = $clog2(DEPTH);

    imem_state_t            state;
    logic [AW:0]            widx;
    logic                   load_hs;
    logic                   load_done;
    logic                   fetch_go;
    logic                   fetch_bad;
    logic                   use_mem;
    logic [InstAddrBus-1:0] addr_off;
    logic [AW-1:0]          rd_idx;
    logic [InstBus-1:0]     rd_data;
    logic                   unused_off;

    assign load_hs   = load_valid_i & (state == ST_LOAD);
    assign load_done = load_last_i | (widx == (AW+1)'(DEPTH - 1));
    assign fetch_go  = inst_ce_i & (state == ST_RUN);

    assign addr_off = inst_addr_i - BASE_ADDR;
    assign rd_idx   = addr_off[AW+1:2];

`ifdef YSYX_2022040010_IMEM_CHECK_EN
    assign fetch_bad  = (inst_addr_i[1:0] != 2'b00)
                      | (inst_addr_i < BASE_ADDR)
                      | (|addr_off[InstAddrBus-1:AW+2]);
    assign unused_off = ^addr_off[1:0];
`else
    // Without checking, the index simply wraps modulo DEPTH.
    assign fetch_bad  = 1'b0;
    assign unused_off = ^{addr_off[InstAddrBus-1:AW+2], addr_off[1:0]};
`endif

    ysyx_2022040010_imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (load_hs),
        .waddr (widx[AW-1:0]),
        .wdata (load_data_i),
        .re    (fetch_go & ~fetch_bad),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // The array read register has no reset, so a registered select decides
    // whether the output shows the stored word or the NOP.
    assign inst_data_o = use_mem ? rd_data : NOP_INST;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_LOAD;
            widx         <= '0;
            load_ready_o <= 1'b1;
            run_o        <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_err_o   <= 1'b0;
            use_mem      <= 1'b0;
            fetch_cnt_o  <= '0;
        end else if (state == ST_LOAD) begin
            if (load_hs) begin
                widx <= widx + (AW+1)'(1);
                if (load_done) begin
                    state        <= ST_RUN;
                    load_ready_o <= 1'b0;
                    run_o        <= 1'b1;
                end
            end
        end else begin
            inst_valid_o <= inst_ce_i;
            inst_err_o   <= inst_ce_i & fetch_bad;
            if (inst_ce_i) begin
                use_mem <= ~fetch_bad;
                if (fetch_cnt_o != 32'hFFFF_FFFF) begin
                    fetch_cnt_o <= fetch_cnt_o + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_imem_resp.sv
// Directed bench for the instruction-memory responder: a default-depth
// instance for load/fetch/check/reset scenarios and a DEPTH=4 instance for fill.
module tb_ysyx_2022040010_imem_resp;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ce = 1'b0;
    logic [63:0] addr = '0;
    logic [31:0] data;
    logic        valid, err, ready, run;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic [31:0] cnt;

    logic        s_ce = 1'b0;
    logic [63:0] s_addr = '0;
    logic [31:0] s_data;
    logic        s_valid, s_err, s_ready, s_run;
    logic        s_ld_valid = 1'b0;
    logic [31:0] s_ld_data = '0;
    logic        s_ld_last = 1'b0;
    logic [31:0] s_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_2022040010_imem_resp u_dut (
        .clk(clk), .rst(rst),
        .inst_ce_i(ce), .inst_addr_i(addr), .inst_data_o(data),
        .inst_valid_o(valid), .inst_err_o(err),
        .load_valid_i(ld_valid), .load_ready_o(ready),
        .load_data_i(ld_data), .load_last_i(ld_last),
        .run_o(run), .fetch_cnt_o(cnt)
    );

    ysyx_2022040010_imem_resp #(.DEPTH(4)) u_small (
        .clk(clk), .rst(rst),
        .inst_ce_i(s_ce), .inst_addr_i(s_addr), .inst_data_o(s_data),
        .inst_valid_o(s_valid), .inst_err_o(s_err),
        .load_valid_i(s_ld_valid), .load_ready_o(s_ready),
        .load_data_i(s_ld_data), .load_last_i(s_ld_last),
        .run_o(s_run), .fetch_cnt_o(s_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (data !== NOP) begin errors++; $display("FAIL reset_data: got %h want %h", data, NOP); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b want 0", run); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        checks++; if (s_ready !== 1'b1 || s_run !== 1'b0) begin errors++; $display("FAIL reset_small: ready=%b run=%b want 1/0", s_ready, s_run); end
    endtask

    task automatic test_fetch_during_load();
        rst  = 1'b1;
        ce   = 1'b1;
        addr = BASE;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL load_fetch_valid: got %b want 0", valid); end
        checks++; if (data !== NOP) begin errors++; $display("FAIL load_fetch_data: got %h want %h", data, NOP); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL load_fetch_cnt: got %0d want 0", cnt); end
    endtask

    task automatic test_load_fetch();
        ld_valid = 1'b1; ld_data = 32'h0010_0093; ld_last = 1'b0;
        tick();
        checks++; if (run !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL load1_state: run=%b ready=%b want 0/1", run, ready); end
        ld_data = 32'h0020_0113; ld_last = 1'b1;
        tick();
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL load_last_run: got %b want 1", run); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL load_last_ready: got %b want 0", ready); end
        checks++; if (valid !== 1'b0 || cnt !== 32'd0) begin errors++; $display("FAIL same_cycle_fetch: valid=%b cnt=%0d want 0/0", valid, cnt); end
        // Load inputs stay active in RUN and must be ignored.
        ld_data = 32'hFFFF_FFFF; ld_last = 1'b0;
        addr = BASE;
        tick();
        checks++; if (data !== 32'h0010_0093 || valid !== 1'b1) begin errors++; $display("FAIL fetch0: data=%h valid=%b want 00100093/1", data, valid); end
        checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL fetch0_cnt: got %0d want 1", cnt); end
        addr = BASE + 64'd4;
        tick();
        checks++; if (data !== 32'h0020_0113 || valid !== 1'b1) begin errors++; $display("FAIL fetch1: data=%h valid=%b want 00200113/1", data, valid); end
        checks++; if (cnt !== 32'd2) begin errors++; $display("FAIL fetch1_cnt: got %0d want 2", cnt); end
        ld_valid = 1'b0;
        ce = 1'b0;
        tick();
        checks++; if (valid !== 1'b0 || data !== 32'h0020_0113) begin errors++; $display("FAIL idle_hold: data=%h valid=%b want 00200113/0", data, valid); end
        checks++; if (cnt !== 32'd2 || ready !== 1'b0) begin errors++; $display("FAIL idle_cnt: cnt=%0d ready=%b want 2/0", cnt, ready); end
    endtask

    task automatic test_checks();
        ce = 1'b1;
        addr = 64'h0000_0000_8000_0002;
        tick();
`ifdef YSYX_2022040010_IMEM_CHECK_EN
        checks++; if (err !== 1'b1 || data !== NOP || valid !== 1'b1) begin errors++; $display("FAIL misaligned: err=%b data=%h valid=%b want 1/%h/1", err, data, valid, NOP); end
`else
        checks++; if (err !== 1'b0 || data !== 32'h0010_0093 || valid !== 1'b1) begin errors++; $display("FAIL misaligned: err=%b data=%h valid=%b want 0/00100093/1", err, data, valid); end
`endif
        addr = 64'h0000_0000_7FFF_FFFC;
        tick();
`ifdef YSYX_2022040010_IMEM_CHECK_EN
        checks++; if (err !== 1'b1 || data !== NOP || valid !== 1'b1) begin errors++; $display("FAIL below_base: err=%b data=%h valid=%b want 1/%h/1", err, data, valid, NOP); end
`else
        checks++; if (err !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL below_base: err=%b valid=%b want 0/1", err, valid); end
`endif
        addr = BASE + 64'd4096;
        tick();
`ifdef YSYX_2022040010_IMEM_CHECK_EN
        checks++; if (err !== 1'b1 || data !== NOP || valid !== 1'b1) begin errors++; $display("FAIL past_end: err=%b data=%h valid=%b want 1/%h/1", err, data, valid, NOP); end
`else
        checks++; if (err !== 1'b0 || data !== 32'h0010_0093 || valid !== 1'b1) begin errors++; $display("FAIL past_end: err=%b data=%h valid=%b want 0/00100093/1", err, data, valid); end
`endif
        checks++; if (cnt !== 32'd5) begin errors++; $display("FAIL check_cnt: got %0d want 5", cnt); end
        addr = BASE + 64'd4;
        tick();
        checks++; if (err !== 1'b0 || data !== 32'h0020_0113) begin errors++; $display("FAIL legal_after: err=%b data=%h want 0/00200113", err, data); end
        checks++; if (cnt !== 32'd6) begin errors++; $display("FAIL legal_cnt: got %0d want 6", cnt); end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b0;
        ce = 1'b1; addr = BASE;
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
        tick();
        checks++; if (cnt !== 32'd0 || run !== 1'b0) begin errors++; $display("FAIL midrun_reset: cnt=%0d run=%b want 0/0", cnt, run); end
        checks++; if (ready !== 1'b1 || valid !== 1'b0 || data !== NOP) begin errors++; $display("FAIL midrun_outs: ready=%b valid=%b data=%h want 1/0/%h", ready, valid, data, NOP); end
        rst = 1'b1;
        ce = 1'b0;
        ld_data = 32'h0050_0293;
        tick();
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL reload_run: got %b want 1", run); end
        ld_valid = 1'b0; ld_last = 1'b0;
        ce = 1'b1; addr = BASE;
        tick();
        checks++; if (data !== 32'h0050_0293 || cnt !== 32'd1) begin errors++; $display("FAIL reload_fetch: data=%h cnt=%0d want 00500293/1", data, cnt); end
        addr = BASE + 64'd4;
        tick();
        checks++; if (data !== 32'h0020_0113) begin errors++; $display("FAIL retained_word: got %h want 00200113", data); end
        ce = 1'b0;
    endtask

    task automatic test_fill_depth();
        s_ld_valid = 1'b1;
        s_ld_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_ld_data = 32'h1111_1111 * (i + 1);
            tick();
            checks++;
            if (s_run !== (i == 3)) begin errors++; $display("FAIL fill_run_%0d: got %b want %b", i, s_run, (i == 3)); end
        end
        s_ld_data = 32'hFFFF_FFFF;
        tick();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_fifth_ready: got %b want 0", s_ready); end
        s_ld_valid = 1'b0;
        s_ce = 1'b1; s_addr = BASE + 64'd8;
        tick();
        checks++; if (s_data !== 32'h3333_3333 || s_valid !== 1'b1) begin errors++; $display("FAIL fill_fetch2: data=%h valid=%b want 33333333/1", s_data, s_valid); end
        s_addr = BASE + 64'd16;
        tick();
`ifdef YSYX_2022040010_IMEM_CHECK_EN
        checks++; if (s_err !== 1'b1 || s_data !== NOP) begin errors++; $display("FAIL fill_wrap: err=%b data=%h want 1/%h", s_err, s_data, NOP); end
`else
        checks++; if (s_err !== 1'b0 || s_data !== 32'h1111_1111) begin errors++; $display("FAIL fill_wrap: err=%b data=%h want 0/11111111", s_err, s_data); end
`endif
        checks++; if (s_cnt !== 32'd2) begin errors++; $display("FAIL fill_cnt: got %0d want 2", s_cnt); end
        s_ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_during_load();
        test_load_fetch();
        test_checks();
        test_reset_mid_run();
        test_fill_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_2022040010_imem_resp.md
# ysyx_2022040010_imem_resp

Instruction-memory responder: the memory end of the core's fetch interface (`inst_ce`/`inst_addr` out of the core, `inst_data` back). Holds the program in a word-addressed array. After reset it is filled through a valid/ready load port, then serves registered 32-bit instruction reads addressed by the core's 64-bit PC. It sits outside the core top, beside the simulation harness, and also counts served fetches for performance reporting.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; must be a power of two, ≥ 2.
- `BASE_ADDR`, 64'h0000_0000_8000_0000: byte address of word 0.
- `NOP_INST`, 32'h0000_0013: word returned when no valid instruction is available (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `inst_ce_i` in 1: fetch enable from the core.
- `inst_addr_i` in 64: fetch byte address (PC).
- `inst_data_o` out 32: fetched instruction, registered.
- `inst_valid_o` out 1: `inst_data_o` holds the result of a fetch accepted in RUN.
- `inst_err_o` out 1: the accepted fetch was illegal (only meaningful with the macro).
- `load_valid_i` in 1: a load word is offered.
- `load_ready_o` out 1: the block can accept a load word.
- `load_data_i` in 32: the load word.
- `load_last_i` in 1: marks the final load word.
- `run_o` out 1: the block is in RUN.
- `fetch_cnt_o` out 32: count of fetches served in RUN.

## Operation
- FSM has two states, LOAD and RUN. Reset enters LOAD.
- **LOAD**
  - `load_ready_o`=1.
  - Handshake = `load_valid_i & load_ready_o`. Each handshake writes `load_data_i` to array[`widx`], then increments `widx`.
  - Go to RUN on a handshake with `load_last_i`=1, or on the handshake that writes index DEPTH-1.
  - Fetches are ignored: `inst_valid_o`=0 and `inst_data_o`=`NOP_INST`.
- **RUN**
  - `load_ready_o`=0 and load inputs are ignored. RUN is left only by reset.
  - Word index = (`inst_addr_i` − `BASE_ADDR`) >> 2, truncated to log2(DEPTH) bits.
  - When `inst_ce_i`=1: read the array, set `inst_valid_o`=1, and increment `fetch_cnt_o` (saturates at 32'hFFFF_FFFF).
  - When `inst_ce_i`=0: `inst_valid_o`=0 and `inst_data_o` holds its previous value.
- The array has no reset. Reset does not clear contents; a new LOAD overwrites from index 0.
- `widx` has log2(DEPTH)+1 bits and is cleared by reset.

## Timing
- Reset values: `inst_data_o`=`NOP_INST`, `inst_valid_o`=0, `inst_err_o`=0, `load_ready_o`=1, `run_o`=0, `fetch_cnt_o`=0, `widx`=0.
- Fetch latency is 1 cycle: address sampled at edge N, data/valid/err visible after edge N and stable until edge N+1.
- A back-to-back fetch every cycle sustains throughput 1.
- `load_ready_o` is a registered function of state: there is no combinational path from `load_valid_i` to `load_ready_o`.
- The last load handshake at edge N makes `run_o`=1 after edge N. A fetch sampled at edge N+1 is served and sees all words written up to and including edge N.
- Reset asserted mid-LOAD or mid-RUN: after that edge all outputs take their reset values and the state is LOAD, regardless of any simultaneous handshake or fetch.
- A fetch presented in the same cycle as the final load handshake is not served (the state is still LOAD at that edge).

## Configuration
- Macro: `YSYX_2022040010_IMEM_CHECK_EN`.
- Defined: a RUN fetch is illegal if any of the following holds:
  - `inst_addr_i[1:0]`≠0
  - `inst_addr_i` < `BASE_ADDR`
  - untruncated index ≥ DEPTH

  An illegal fetch returns `inst_data_o`=`NOP_INST`, `inst_valid_o`=1, `inst_err_o`=1, and still increments the counter. Legal fetches set `inst_err_o`=0.
- Not defined: no checks. `inst_addr_i[1:0]` is ignored, the index wraps modulo DEPTH, and `inst_err_o` is tied to 0.

## Structure
- Shared defines/package holds: `NOP_INST` value, the LOAD/RUN state encoding, and the existing `InstBus` (31:0) and `InstAddrBus` (63:0) widths.
- One sub-module, `ysyx_2022040010_imem_array`: DEPTH×32 storage with one synchronous write port and one registered read port, no reset.
- FSM, index arithmetic, checking and counter stay in the top block.

## Test plan
- **Reset state:** hold `rst`=0 for 2 cycles → all outputs at reset values, `load_ready_o`=1, `run_o`=0.
- **Load then fetch:**
  - Stimulus: load 32'h0010_0093, 32'h0020_0113 (last), then fetch 64'h8000_0000 and 64'h8000_0004 on consecutive cycles.
  - Response: `run_o`=1 one cycle after the last handshake; data 32'h0010_0093 then 32'h0020_0113, `inst_valid_o`=1 both cycles; `fetch_cnt_o`=2.
- **Fetch during LOAD:** `inst_ce_i`=1 with address 64'h8000_0000 → `inst_valid_o`=0, data=32'h0000_0013, `fetch_cnt_o`=0.
- **Fill to DEPTH:** with DEPTH=4, load 4 words without `load_last_i` → RUN entered after the 4th handshake; a 5th `load_valid_i` sees `load_ready_o`=0.
- **Checks (macro defined):**
  - Stimulus: fetch 64'h8000_0002, then 64'h7FFF_FFFC, then BASE+4·DEPTH.
  - Response: each gives `inst_err_o`=1 with data=`NOP_INST`.
  - Without the macro: BASE+4·DEPTH returns word 0 and `inst_err_o`=0.
- **Reset mid-RUN:** after 5 fetches assert `rst`=0 for 1 cycle → `fetch_cnt_o`=0, `run_o`=0. Reload one word marked last, fetch BASE → the new word is returned.
